// File: rtl/logistic_snd_poly.sv
// Logistic-map sonifier: fixed-point x <= r*x*(1-x) drives a bank of square-wave NCOs mixed by sigma-delta PWM.
// Optional LOGISTIC_SND_DITHER_EN adds a 16-bit Galois LFSR that dithers the x LSB.
module logistic_snd_poly #(
  parameter int N_OSC      = 8,
  parameter int FRAC       = 10,
  parameter int ITER_LEN   = 100,
  parameter int R_INC      = 1000,
  parameter int R_MIN      = 32'h440,
  parameter int R_MAX      = 32'hFFF,
  parameter int R_STEP     = 4,
  parameter int PHASE_BITS = 12,
  parameter int PHASE_DEC  = 9,
  parameter int LO_INC     = 16,
  parameter int HI_INC     = 96
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    mode,
  input  logic [FRAC+1:0]               r_hold,
  input  logic [$clog2(N_OSC+1)-1:0]    n_active,
  output logic [FRAC-1:0]               x_out,
  output logic                          x_valid,
  output logic [FRAC+1:0]               r_out,
  output logic                          snd
);

  localparam int NW  = $clog2(N_OSC + 1);
  localparam int ICW = $clog2(ITER_LEN);
  localparam int RCW = (R_INC > 1) ? $clog2(R_INC) : 1;
  localparam int RW  = FRAC + 2;
  localparam int YW  = FRAC + 3;
  localparam int PW  = 2 * FRAC + 1;
  localparam int QW  = 2 * FRAC + 3;

  localparam logic [FRAC:0]     ONE_W      = {1'b1, {FRAC{1'b0}}};
  localparam logic [FRAC-1:0]   X_INIT     = {1'b1, {(FRAC-1){1'b0}}};
  localparam logic [FRAC-1:0]   X_MIN      = {{(FRAC-1){1'b0}}, 1'b1};
  localparam logic [FRAC-1:0]   X_MAX      = {FRAC{1'b1}};
  localparam logic [RW-1:0]     R_MIN_V    = RW'(R_MIN);
  localparam logic [RW-1:0]     R_MAX_V    = RW'(R_MAX);
  localparam logic [RW-1:0]     R_STEP_V   = RW'(R_STEP);
  localparam logic [YW-1:0]     R_MAX_E    = YW'(R_MAX);
  localparam logic [YW-1:0]     R_LOW_E    = YW'(R_MIN + R_STEP);
  localparam logic [YW-1:0]     R_STEP_E   = YW'(R_STEP);
  localparam logic [ICW-1:0]    WAIT_LAST  = ICW'(ITER_LEN - 4);
  localparam logic [RCW-1:0]    RCNT_LAST  = RCW'(R_INC - 1);
  localparam logic [NW-1:0]     N_MAX      = NW'(N_OSC);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_MUL1 = 2'd1,
    S_MUL2 = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [FRAC-1:0] clamp_x(input logic [YW-1:0] y);
    logic [FRAC-1:0] res;
    if (y == {YW{1'b0}}) res = X_MIN;
    else if (y >= {2'b00, ONE_W}) res = X_MAX;
    else res = y[FRAC-1:0];
    return res;
  endfunction

  function automatic logic [NW-1:0] clamp_n(input logic [NW-1:0] n);
    logic [NW-1:0] res;
    if (n == {NW{1'b0}}) res = NW'(1);
    else if (n > N_MAX) res = N_MAX;
    else res = n;
    return res;
  endfunction

  state_t                  state_r, state_nxt_s;
  logic [ICW-1:0]          it_cnt_r;
  logic [FRAC:0]           t_r;
  logic [YW-1:0]           y_r;
  logic [FRAC-1:0]         x_r;
  logic                    x_valid_r;
  logic [RW-1:0]           r_r;
  logic                    dir_up_r;
  logic [RCW-1:0]          r_cnt_r;
  logic [NW-1:0]           ptr_r;
  logic [NW-1:0]           n_eff_r;
  logic [PHASE_BITS-1:0]   freq_r  [N_OSC];
  logic [PHASE_BITS-1:0]   phase_r [N_OSC];
  logic [PHASE_DEC-1:0]    pre_r;
  logic [NW:0]             acc_r;
  logic                    snd_r;

  logic [PW-1:0]           prod1_s;
  logic [QW-1:0]           prod2_s;
  logic [FRAC-1:0]         x_clamp_s;
  logic [FRAC-1:0]         x_new_s;
  logic [31:0]             fprod_s;
  logic [PHASE_BITS-1:0]   freq_new_s;
  logic [YW-1:0]           up_e_s;
  logic [RW-1:0]           r_nxt_s;
  logic                    dir_nxt_s;
  logic                    r_upd_s;
  logic [NW-1:0]           n_eff_s, ptr_eff_s, ptr_inc_s, ptr_nxt_s;
  logic [NW:0]             s_s, sum_s;
  logic                    tick_s;

  assign x_out   = x_r;
  assign x_valid = x_valid_r;
  assign r_out   = r_r;
  assign snd     = snd_r;

  assign prod1_s   = {{(FRAC+1){1'b0}}, x_r} * {{FRAC{1'b0}}, (ONE_W - {1'b0, x_r})};
  assign prod2_s   = {{(FRAC+1){1'b0}}, r_r} * {{RW{1'b0}}, t_r};
  assign x_clamp_s = clamp_x(y_r);
  assign tick_s    = &pre_r;

`ifdef LOGISTIC_SND_DITHER_EN
  logic [15:0]     lfsr_r;
  logic [FRAC-1:0] x_dith_s;

  // Dither source: Galois LFSR advancing once per iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_r <= 16'hACE1;
    else if (state_r == S_DONE) lfsr_r <= {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);
  end

  // Dithered x, kept away from the zero fixed point
  always_comb begin
    x_dith_s = x_clamp_s ^ {{(FRAC-1){1'b0}}, lfsr_r[0]};
    if (x_dith_s == {FRAC{1'b0}}) x_new_s = X_MIN;
    else x_new_s = x_dith_s;
  end
`else
  assign x_new_s = x_clamp_s;
`endif

  assign fprod_s    = 32'(HI_INC - LO_INC) * {{(32-FRAC){1'b0}}, x_new_s};
  assign freq_new_s = PHASE_BITS'(32'(LO_INC) + (fprod_s >> FRAC));

  // Iteration FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_WAIT;
    else state_r <= state_nxt_s;
  end

  // Iteration FSM next state: the WAIT dwell pads the loop to ITER_LEN clocks
  always_comb begin
    state_nxt_s = S_WAIT;
    case (state_r)
      S_WAIT:  if (it_cnt_r == WAIT_LAST) state_nxt_s = S_MUL1; else state_nxt_s = S_WAIT;
      S_MUL1:  state_nxt_s = S_MUL2;
      S_MUL2:  state_nxt_s = S_DONE;
      S_DONE:  state_nxt_s = S_WAIT;
      default: state_nxt_s = S_WAIT;
    endcase
  end

  // Next r for the selected sweep mode; bounds tested one bit wider to avoid wrap
  always_comb begin
    up_e_s    = {1'b0, r_r} + R_STEP_E;
    r_nxt_s   = r_r;
    dir_nxt_s = dir_up_r;
    case (mode)
      2'b00: if (up_e_s > R_MAX_E) r_nxt_s = R_MIN_V; else r_nxt_s = up_e_s[RW-1:0];
      2'b01: if ({1'b0, r_r} < R_LOW_E) r_nxt_s = R_MAX_V; else r_nxt_s = r_r - R_STEP_V;
      2'b10: begin
        if (dir_up_r) begin
          if (up_e_s > R_MAX_E) begin
            r_nxt_s   = R_MAX_V;
            dir_nxt_s = 1'b0;
          end else begin
            r_nxt_s   = up_e_s[RW-1:0];
          end
        end else begin
          if ({1'b0, r_r} < R_LOW_E) begin
            r_nxt_s   = R_MIN_V;
            dir_nxt_s = 1'b1;
          end else begin
            r_nxt_s   = r_r - R_STEP_V;
          end
        end
      end
      2'b11:   r_nxt_s = r_hold;
      default: r_nxt_s = r_r;
    endcase
    r_upd_s = (mode == 2'b11) || (r_cnt_r == {RCW{1'b0}});
  end

  // Voice pointer: clamp to the live voice count before writing, then advance
  always_comb begin
    n_eff_s = clamp_n(n_active);
    if (ptr_r >= n_eff_s) ptr_eff_s = {NW{1'b0}};
    else ptr_eff_s = ptr_r;
    ptr_inc_s = ptr_eff_s + NW'(1);
    if (ptr_inc_s == n_eff_s) ptr_nxt_s = {NW{1'b0}};
    else ptr_nxt_s = ptr_inc_s;
  end

  // Map datapath, r sweep and voice frequency writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      it_cnt_r  <= {ICW{1'b0}};
      t_r       <= {(FRAC+1){1'b0}};
      y_r       <= {YW{1'b0}};
      x_r       <= X_INIT;
      x_valid_r <= 1'b0;
      r_r       <= R_MIN_V;
      dir_up_r  <= 1'b1;
      r_cnt_r   <= {RCW{1'b0}};
      ptr_r     <= {NW{1'b0}};
      n_eff_r   <= NW'(1);
      for (int i = 0; i < N_OSC; i++) freq_r[i] <= {PHASE_BITS{1'b0}};
    end else begin
      if (state_r == S_WAIT && it_cnt_r != WAIT_LAST) it_cnt_r <= it_cnt_r + ICW'(1);
      else it_cnt_r <= {ICW{1'b0}};
      if (state_r == S_MUL1) t_r <= (FRAC+1)'(prod1_s >> FRAC);
      if (state_r == S_MUL2) y_r <= YW'(prod2_s >> FRAC);
      x_valid_r <= (state_r == S_DONE);
      if (state_r == S_DONE) begin
        x_r <= x_new_s;
        if (r_upd_s) begin
          r_r      <= r_nxt_s;
          dir_up_r <= dir_nxt_s;
        end
        if (r_cnt_r == RCNT_LAST) r_cnt_r <= {RCW{1'b0}};
        else r_cnt_r <= r_cnt_r + RCW'(1);
        ptr_r   <= ptr_nxt_s;
        n_eff_r <= n_eff_s;
        for (int i = 0; i < N_OSC; i++) begin
          if (NW'(i) == ptr_eff_s) freq_r[i] <= freq_new_s;
        end
      end
    end
  end

  // NCO bank: every voice advances on the shared prescaler tick
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= {PHASE_DEC{1'b0}};
      for (int i = 0; i < N_OSC; i++) phase_r[i] <= {PHASE_BITS{1'b0}};
    end else begin
      pre_r <= pre_r + PHASE_DEC'(1);
      for (int i = 0; i < N_OSC; i++) begin
        if (tick_s) phase_r[i] <= phase_r[i] + freq_r[i];
      end
    end
  end

  // Count of live voices currently high
  always_comb begin
    s_s = {(NW+1){1'b0}};
    for (int i = 0; i < N_OSC; i++) begin
      if ((NW'(i) < n_eff_r) && phase_r[i][PHASE_BITS-1]) s_s = s_s + (NW+1)'(1);
      else s_s = s_s;
    end
    sum_s = acc_r + s_s;
  end

  // First-order sigma-delta: duty of snd equals s/n_eff exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {(NW+1){1'b0}};
      snd_r <= 1'b0;
    end else if (sum_s >= {1'b0, n_eff_r}) begin
      acc_r <= sum_s - {1'b0, n_eff_r};
      snd_r <= 1'b1;
    end else begin
      acc_r <= sum_s;
      snd_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logistic_snd_poly.sv
// Randomized bench for logistic_snd_poly against an arithmetic reference model of the map, sweep, voices and mixer.
module tb_logistic_snd_poly;

  localparam int N_OSC      = 8;
  localparam int FRAC       = 10;
  localparam int ITER_LEN   = 100;
  localparam int R_INC      = 2;
  localparam int R_MIN      = 32'h440;
  localparam int R_MAX      = 32'hFFF;
  localparam int R_STEP     = 4;
  localparam int PHASE_BITS = 12;
  localparam int PHASE_DEC  = 4;
  localparam int LO_INC     = 16;
  localparam int HI_INC     = 96;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic [11:0] r_hold;
  logic [3:0]  n_active;
  logic [9:0]  x_out;
  logic        x_valid;
  logic [11:0] r_out;
  logic        snd;

  always #5 clk = ~clk;

  logistic_snd_poly #(
    .N_OSC(N_OSC), .FRAC(FRAC), .ITER_LEN(ITER_LEN), .R_INC(R_INC),
    .R_MIN(R_MIN), .R_MAX(R_MAX), .R_STEP(R_STEP), .PHASE_BITS(PHASE_BITS),
    .PHASE_DEC(PHASE_DEC), .LO_INC(LO_INC), .HI_INC(HI_INC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .r_hold(r_hold), .n_active(n_active),
    .x_out(x_out), .x_valid(x_valid), .r_out(r_out), .snd(snd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_cyc, m_x, m_r, m_cnt, m_up, m_ptr, m_neff, m_acc, m_snd, m_xv;
  int m_freq [N_OSC];
  int m_phase [N_OSC];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff_n(input int n);
    if (n == 0) return 1;
    if (n > N_OSC) return N_OSC;
    return n;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_x = 512; m_r = R_MIN; m_cnt = 0; m_up = 1;
    m_ptr = 0; m_neff = 1; m_acc = 0; m_snd = 0; m_xv = 0;
    for (int i = 0; i < N_OSC; i++) begin
      m_freq[i] = 0;
      m_phase[i] = 0;
    end
  endtask

  // One clock of the model; every update reads the state from before the edge.
  task automatic model_edge();
    int s, t, y, ne, p, nr;
    m_cyc++;
    s = 0;
    for (int i = 0; i < m_neff; i++) if (m_phase[i] >= (1 << (PHASE_BITS - 1))) s++;
    if (m_acc + s >= m_neff) begin
      m_snd = 1; m_acc = m_acc + s - m_neff;
    end else begin
      m_snd = 0; m_acc = m_acc + s;
    end
    if (m_cyc % (1 << PHASE_DEC) == 0)
      for (int i = 0; i < N_OSC; i++) m_phase[i] = (m_phase[i] + m_freq[i]) % (1 << PHASE_BITS);
    m_xv = (m_cyc % ITER_LEN == 0) ? 1 : 0;
    if (m_xv == 1) begin
      t = (m_x * (1024 - m_x)) >> FRAC;
      y = (m_r * t) >> FRAC;
      if (y == 0) m_x = 1;
      else if (y >= 1024) m_x = 1023;
      else m_x = y;
      if (int'(mode) == 3) m_r = int'(r_hold);
      else if (m_cnt == 0) begin
        if (int'(mode) == 0) begin
          nr = m_r + R_STEP;
          m_r = (nr > R_MAX) ? R_MIN : nr;
        end else if (int'(mode) == 1) begin
          nr = m_r - R_STEP;
          m_r = (nr < R_MIN) ? R_MAX : nr;
        end else if (m_up == 1) begin
          nr = m_r + R_STEP;
          if (nr > R_MAX) begin m_r = R_MAX; m_up = 0; end else m_r = nr;
        end else begin
          nr = m_r - R_STEP;
          if (nr < R_MIN) begin m_r = R_MIN; m_up = 1; end else m_r = nr;
        end
      end
      m_cnt = (m_cnt + 1) % R_INC;
      ne = eff_n(int'(n_active));
      p = (m_ptr >= ne) ? 0 : m_ptr;
      m_freq[p] = LO_INC + (((HI_INC - LO_INC) * m_x) >> FRAC);
      m_ptr = (p + 1) % ne;
      m_neff = ne;
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    check_eq("x_out", 32'(x_out), 32'(m_x));
    check_eq("r_out", 32'(r_out), 32'(m_r));
    check_eq("x_valid", 32'(x_valid), 32'(m_xv));
    check_eq("snd", 32'(snd), 32'(m_snd));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step_clk();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_x"}, 32'(x_out), 32'h200);
    check_eq({tag, "_r"}, 32'(r_out), 32'h440);
    check_eq({tag, "_snd"}, 32'(snd), 32'h0);
    check_eq({tag, "_xv"}, 32'(x_valid), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; mode = 2'd3; r_hold = 12'h800; n_active = 4'd4;
    model_reset();
    #12;
    check_reset_outputs("rst");
    run(3);
    rst_n = 1'b1;

    // first iteration from reset: x=0.5, r=R_MIN -> y = (1088*256)>>10 = 272
    run(ITER_LEN - 1);
    check_eq("first_xv_early", 32'(x_valid), 32'h0);
    run(1);
    check_eq("first_xv", 32'(x_valid), 32'h1);
    check_eq("first_x", 32'(x_out), 32'h110);
    check_eq("first_r", 32'(r_out), 32'h800);

    // sweep edges around the top and bottom of the r range
    n_active = 4'd0;  mode = 2'd3; r_hold = 12'hFFC; run(2 * ITER_LEN);
    mode = 2'd0;      run(5 * ITER_LEN);
    n_active = 4'd3;  mode = 2'd3; r_hold = 12'hFFC; run(2 * ITER_LEN);
    mode = 2'd2;      run(6 * ITER_LEN);
    n_active = 4'd9;  mode = 2'd3; r_hold = 12'h444; run(2 * ITER_LEN);
    mode = 2'd1;      run(4 * ITER_LEN);
    mode = 2'd2;      run(6 * ITER_LEN);

    // asynchronous reset in the middle of an iteration
    run(37);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    run(3);
    rst_n = 1'b1;
    run(ITER_LEN - 1);
    check_eq("rel_xv_early", 32'(x_valid), 32'h0);
    run(1);
    check_eq("rel_xv", 32'(x_valid), 32'h1);

    // random modes, r_hold values and voice counts, changed at arbitrary clocks
    for (int it = 0; it < 120; it++) begin
      mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) r_hold = 12'($urandom_range(0, 4095));
      else r_hold = 12'($urandom_range(R_MIN, R_MAX));
      n_active = 4'($urandom_range(0, 15));
      run($urandom_range(30, 400));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
